// File: rtl/cu_command_arbiter_pkg.sv
// Shared CU definitions: requester indices, default sizes and the command buffer line format.
package cu_command_arbiter_pkg;

    localparam int NUM_REQUESTS_DEFAULT = 3;
    localparam int COUNT_BITS_DEFAULT   = 32;

    // Requester index of each CU engine on the shared command path
    localparam int CMD_REQ_READ     = 0;
    localparam int CMD_REQ_WRITE    = 1;
    localparam int CMD_REQ_PREFETCH = 2;

    // One command buffer entry; valid marks a presented/issued command
    typedef struct packed {
        logic        valid;
        logic [3:0]  command;
        logic [7:0]  tag;
        logic [31:0] address;
    } CommandBufferLine;

endpackage

// File: rtl/cu_command_arbiter_round_robin_priority_select.sv
// Combinational round-robin search: first set bit of valid at or after ptr, wrapping.
module round_robin_priority_select #(
    parameter int NUM_REQUESTS = 3,
    parameter int INDEX_BITS   = $clog2(NUM_REQUESTS)
) (
    input  logic [NUM_REQUESTS-1:0] valid,
    input  logic [INDEX_BITS-1:0]   ptr,
    output logic                    found,
    output logic [INDEX_BITS-1:0]   index
);

    localparam int WIDE_BITS = INDEX_BITS + 1;

    // Scan from the farthest offset back towards ptr so the nearest valid slot wins
    always_comb begin
        logic [WIDE_BITS-1:0] candidate;
        candidate = '0;
        found     = 1'b0;
        index     = '0;
        for (int k = NUM_REQUESTS - 1; k >= 0; k--) begin
            candidate = {1'b0, ptr} + WIDE_BITS'(k);
            if (candidate >= WIDE_BITS'(NUM_REQUESTS)) begin
                candidate = candidate - WIDE_BITS'(NUM_REQUESTS);
            end
            if (valid[candidate[INDEX_BITS-1:0]]) begin
                found = 1'b1;
                index = candidate[INDEX_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/cu_command_arbiter.sv
// Round-robin arbiter sharing the CU command path between the read, write and prefetch engines.
module cu_command_arbiter
    import cu_command_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTS = NUM_REQUESTS_DEFAULT,
    parameter int COUNT_BITS   = COUNT_BITS_DEFAULT
) (
    input  logic                                     clock,
    input  logic                                     rstn,
    input  logic                                     enabled_in,
    input  logic                                     command_buffer_alfull,
    input  CommandBufferLine [NUM_REQUESTS-1:0]      command_in,
    output logic [NUM_REQUESTS-1:0]                  command_ready_out,
    output CommandBufferLine                         command_out,
    output logic [NUM_REQUESTS-1:0]                  grant_out,
    output logic [NUM_REQUESTS-1:0][COUNT_BITS-1:0]  issue_count_out
);

    localparam int INDEX_BITS = $clog2(NUM_REQUESTS);

    CommandBufferLine          slot_cmd_reg   [NUM_REQUESTS];
    logic                      slot_valid_reg [NUM_REQUESTS];
    logic [COUNT_BITS-1:0]     count_reg      [NUM_REQUESTS];
    logic [NUM_REQUESTS-1:0]   slot_valid;
    logic [INDEX_BITS-1:0]     ptr_reg;
    logic [INDEX_BITS-1:0]     ptr_next;
    CommandBufferLine          command_reg;
    CommandBufferLine          command_next;
    logic [NUM_REQUESTS-1:0]   grant_reg;
    logic [NUM_REQUESTS-1:0]   grant_next;
    logic                      found;
    logic [INDEX_BITS-1:0]     winner;
    logic                      issue;

    // A slot can only accept while empty; reset also holds ready low since it drops any capture
    assign command_ready_out = {NUM_REQUESTS{enabled_in & ~rstn}} & ~slot_valid;

    round_robin_priority_select #(
        .NUM_REQUESTS (NUM_REQUESTS),
        .INDEX_BITS   (INDEX_BITS)
    ) u_select (
        .valid (slot_valid),
        .ptr   (ptr_reg),
        .found (found),
        .index (winner)
    );

    // found is set exactly when any slot is valid, since ptr is always in range
    assign issue = enabled_in & ~command_buffer_alfull & found;

    // Winner's command, one-hot source and the rotated priority pointer
    always_comb begin
        command_next = '0;
        grant_next   = '0;
        ptr_next     = ptr_reg;
        if (issue) begin
            command_next       = slot_cmd_reg[winner];
            command_next.valid = 1'b1;
            grant_next         = NUM_REQUESTS'(1) << winner;
            ptr_next           = (winner == INDEX_BITS'(NUM_REQUESTS - 1)) ? '0 : winner + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQUESTS; gi++) begin : g_slot
            assign slot_valid[gi]      = slot_valid_reg[gi];
            assign issue_count_out[gi] = count_reg[gi];

            // Holding slot: load on accept, free on grant (never both in one cycle)
            always_ff @(posedge clock) begin
                if (rstn) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_cmd_reg[gi]   <= '0;
                end else if (command_ready_out[gi] && command_in[gi].valid) begin
                    slot_valid_reg[gi] <= 1'b1;
                    slot_cmd_reg[gi]   <= command_in[gi];
                end else if (grant_next[gi]) begin
                    slot_valid_reg[gi] <= 1'b0;
                end
            end

            // Issued-command counter, wraps naturally
            always_ff @(posedge clock) begin
                if (rstn) begin
                    count_reg[gi] <= '0;
                end else if (grant_next[gi]) begin
                    count_reg[gi] <= count_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // Output registers and priority pointer; outputs return to zero when nothing issues
    always_ff @(posedge clock) begin
        if (rstn) begin
            ptr_reg     <= '0;
            command_reg <= '0;
            grant_reg   <= '0;
        end else begin
            ptr_reg     <= ptr_next;
            command_reg <= command_next;
            grant_reg   <= grant_next;
        end
    end

    assign command_out = command_reg;
    assign grant_out   = grant_reg;

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Directed bench with per-requester scoreboard queues for cu_command_arbiter.
module tb_cu_command_arbiter;
    import cu_command_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int CB = 4;

    logic                        clock = 1'b0;
    logic                        rstn;
    logic                        enabled_in;
    logic                        command_buffer_alfull;
    CommandBufferLine [N-1:0]    command_in;
    logic [N-1:0]                command_ready_out;
    CommandBufferLine            command_out;
    logic [N-1:0]                grant_out;
    logic [N-1:0][CB-1:0]        issue_count_out;

    always #5 clock = ~clock;

    cu_command_arbiter #(
        .NUM_REQUESTS (N),
        .COUNT_BITS   (CB)
    ) dut (
        .clock                 (clock),
        .rstn                  (rstn),
        .enabled_in            (enabled_in),
        .command_buffer_alfull (command_buffer_alfull),
        .command_in            (command_in),
        .command_ready_out     (command_ready_out),
        .command_out           (command_out),
        .grant_out             (grant_out),
        .issue_count_out       (issue_count_out)
    );

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    CommandBufferLine exp_q [N][$];
    logic [N-1:0]     m_pend;
    int               m_ptr;
    int               m_cnt [N];
    int               acc_total [N];
    logic [7:0]       tag_seq = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic CommandBufferLine new_cmd(input int i);
        CommandBufferLine c;
        c.valid   = 1'b1;
        c.command = 4'(i + 1);
        c.tag     = tag_seq;
        c.address = $urandom;
        tag_seq   = tag_seq + 8'd1;
        return c;
    endfunction

    // One clock cycle: check ready mid-cycle, predict the edge, check outputs just after it
    task automatic tick();
        logic [N-1:0]     rdy_exp;
        logic [N-1:0]     acc;
        CommandBufferLine acc_cmd [N];
        logic             iss;
        int               g;
        CommandBufferLine exp_out;
        logic [N-1:0]     exp_grant;
        #2;
        for (int i = 0; i < N; i++) begin
            rdy_exp[i] = enabled_in && !rstn && !m_pend[i];
            acc[i]     = rdy_exp[i] && command_in[i].valid;
            acc_cmd[i] = command_in[i];
        end
        chk("ready", 64'(command_ready_out), 64'(rdy_exp));
        iss = enabled_in && !command_buffer_alfull && (m_pend != '0) && !rstn;
        g = -1;
        if (iss) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        exp_out   = '0;
        exp_grant = '0;
        if (rstn) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                m_cnt[i] = 0;
            end
            m_pend = '0;
            m_ptr  = 0;
        end else begin
            if (iss) begin
                exp_out      = exp_q[g].pop_front();
                exp_grant[g] = 1'b1;
                m_pend[g]    = 1'b0;
                m_ptr        = (g + 1) % N;
                m_cnt[g]     = (m_cnt[g] + 1) % (1 << CB);
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    exp_q[i].push_back(acc_cmd[i]);
                    m_pend[i] = 1'b1;
                    acc_total[i]++;
                end
            end
        end
        chk("command_out", 64'(command_out), 64'(exp_out));
        chk("grant_out", 64'(grant_out), 64'(exp_grant));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("count%0d", i), 64'(issue_count_out[i]), 64'(m_cnt[i]));
        end
        if (command_out.valid === 1'b1) begin
            $display("cycle %0d issue grant=%b tag=%02h addr=%08h counts=%0d/%0d/%0d",
                     cyc, grant_out, command_out.tag, command_out.address,
                     issue_count_out[0], issue_count_out[1], issue_count_out[2]);
        end
    endtask

    task automatic reset_dut();
        rstn       = 1'b1;
        command_in = '0;
        tick();
        rstn = 1'b0;
    endtask

    initial begin
        int lo;
        int hi;
        int start0;
        m_pend = '0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]     = 0;
            acc_total[i] = 0;
        end

        // Reset for two cycles while requester 0 presents a command
        rstn                  = 1'b1;
        enabled_in            = 1'b1;
        command_buffer_alfull = 1'b0;
        command_in            = '0;
        command_in[0]         = new_cmd(0);
        tick();
        tick();
        rstn       = 1'b0;
        command_in = '0;
        tick();

        // Single request from requester 1: visible two cycles after capture
        command_in[1] = new_cmd(1);
        tick();
        command_in = '0;
        tick();
        chk("single_grant", 64'(grant_out), 64'(3'b010));
        chk("single_count", 64'(issue_count_out[1]), 64'd1);
        tick();
        tick();

        // Fairness: everyone presents every cycle for 30 cycles
        reset_dut();
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) command_in[i] = new_cmd(i);
            tick();
        end
        command_in = '0;
        repeat (4) tick();
        lo = 1 << CB;
        hi = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(issue_count_out[i]) < lo) lo = int'(issue_count_out[i]);
            if (int'(issue_count_out[i]) > hi) hi = int'(issue_count_out[i]);
        end
        chk("fair_spread_ok", 64'(hi - lo <= 1), 64'd1);

        // Back-pressure: almost-full for 10 cycles with all requesters active
        reset_dut();
        command_buffer_alfull = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) command_in[i] = new_cmd(i);
            tick();
        end
        chk("bp_ready_blocked", 64'(command_ready_out), 64'd0);
        command_buffer_alfull = 1'b0;
        for (int i = 0; i < N; i++) command_in[i] = new_cmd(i);
        tick();
        chk("bp_resume_valid", 64'(command_out.valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) command_in[i] = new_cmd(i);
            tick();
        end
        command_in = '0;
        repeat (4) tick();

        // Enable gating with slots 0 and 2 pending
        command_buffer_alfull = 1'b1;
        command_in[0] = new_cmd(0);
        command_in[2] = new_cmd(2);
        tick();
        command_in            = '0;
        command_buffer_alfull = 1'b0;
        enabled_in            = 1'b0;
        repeat (5) tick();
        enabled_in = 1'b1;
        repeat (3) tick();

        // Reset while slot 2 is pending: slot dropped, pointer back to 0
        command_buffer_alfull = 1'b1;
        command_in[2] = new_cmd(2);
        tick();
        command_in = '0;
        rstn       = 1'b1;
        tick();
        rstn                  = 1'b0;
        command_buffer_alfull = 1'b0;
        tick();
        chk("rst_slot_dropped", 64'(command_ready_out), 64'(3'b111));
        for (int i = 0; i < N; i++) command_in[i] = new_cmd(i);
        tick();
        command_in = '0;
        tick();
        chk("rst_ptr_zero", 64'(grant_out), 64'(3'b001));
        repeat (3) tick();

        // Counter wrap: 17 commands from requester 0 on a 4-bit counter
        reset_dut();
        start0 = acc_total[0];
        for (int c = 0; c < 60; c++) begin
            command_in[0] = (acc_total[0] - start0 < 17) ? new_cmd(0) : CommandBufferLine'('0);
            tick();
        end
        chk("wrap_count0", 64'(issue_count_out[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
